memory_block_copier: RTL and testbench
======================================

# memory_block_copier

Bus initiator for the 256×8 single-port memory. On a start request it copies `len` bytes from `src_addr` to `dst_addr` by driving the memory's `address`, `data`, `wr` and `cs` pins, then reports completion. It sits between the control logic and the memory, as the only master on the memory bus while busy.

## Interface
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 8: memory data width.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a copy; sampled only in IDLE.
- `abort`  in  1  terminate an active copy early.
- `src_addr`  in  ADDR_W  first source address; captured on accepted start.
- `dst_addr`  in  ADDR_W  first destination address; captured on accepted start.
- `len`  in  9  byte count, 0..256; captured on accepted start.
- `busy`  out  1  high from the cycle after an accepted start until DONE is left.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`; high if the copy was aborted.
- `checksum`  out  DATA_W  sum of bytes written (see Configuration).
- `mem_address`  out  ADDR_W  to memory `address`.
- `mem_data`  out  DATA_W  to memory `data`.
- `mem_wr`  out  1  to memory `wr`: 0 = read, 1 = write.
- `mem_cs`  out  1  to memory `cs`, active-low.
- `mem_o`  in  DATA_W  from memory `o`; combinational read data, Z when not selected.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: `mem_cs`=1, `mem_wr`=0. On `start`=1, capture `src_addr`, `dst_addr` and `len` into `src_ptr`, `dst_ptr` and `remaining`, then go to READ. If `len`=0, go directly to DONE with no bus access. `len` > 256 is treated as 256.
- READ: `mem_cs`=0, `mem_wr`=0, `mem_address`=`src_ptr`. At the clock edge, capture `mem_o` into `data_reg` and go to WRITE.
- WRITE: `mem_cs`=0, `mem_wr`=1, `mem_address`=`dst_ptr`, `mem_data`=`data_reg`. The memory writes at this edge. At the same edge, `src_ptr`++, `dst_ptr`++ and `remaining`--. If `remaining`=1, go to DONE; otherwise go to READ.
- Pointers wrap modulo 256 (8'hFF+1 → 8'h00). Overlapping regions are copied strictly in ascending order, with no overlap correction.
- Abort sampled in READ: go to DONE; no write of that byte.
- Abort sampled in WRITE: the write at this edge completes, then go to DONE.
- In both abort cases, `aborted` is set for the DONE cycle.
- DONE: `done`=1 for exactly one cycle, bus is idle (`mem_cs`=1), then go to IDLE. `start` is ignored in DONE.
- Bus outputs decode only from the state and registers, with no combinational path from `start`/`abort`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `aborted`=0, `checksum`=0, `mem_cs`=1, `mem_wr`=0, `mem_address`=0, `mem_data`=0.
- Reset asserted mid-copy aborts immediately. Bus returns to idle asynchronously and no `done` pulse is produced.
- Two cycles per byte. From the edge that accepts `start` to the `done` cycle: 2·len+1 cycles for len ≥ 1, and 1 cycle for len=0.
- `busy` is high in READ, WRITE and DONE.
- Back-to-back operation: `start` held high is accepted again on the first IDLE cycle after DONE.

## Configuration
- Macro: `MEMORY_BLOCK_COPIER_CHECKSUM_EN`.
- Defined:
  - `checksum` is cleared on an accepted start.
  - It adds `data_reg` modulo 256 at every WRITE edge.
  - It is stable from the `done` cycle until the next accepted start.
- Undefined: `checksum` is tied to 8'h00 and the accumulator logic is absent.

## Structure
- Shared package `memory_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - Copier state enum.
  - Memory depth constant 256.
  - `CS_ACTIVE`=1'b0 and `WR_READ`/`WR_WRITE` encodings.
- One natural sub-module, `copy_checksum`: accumulator with clear/enable, instantiated only under the macro.

## Test plan
- Memory preloaded 0x10..0x13 = AA,BB,CC,DD; start src=0x10, dst=0x80, len=4 → 0x80..0x83 = AA,BB,CC,DD; `done` 9 cycles after the start edge; checksum 0x0E (macro on).
- len=0 → `done` next cycle; `mem_cs` never low; memory unchanged.
- src=0xFE, dst=0x02, len=4 → reads 0xFE,0xFF,0x00,0x01 and writes 0x02..0x05 in order (wrap check).
- Abort asserted during 3rd READ of len=8 → exactly 2 bytes written; `done`=1 with `aborted`=1.
- `reset_n` pulsed low during a WRITE → `mem_cs`=1 immediately, `busy`=0, no `done`; next start runs normally.
- `start` held high for 2 back-to-back copies of len=1 → two `done` pulses 4 cycles apart; `start` ignored while busy.

Source files
------------

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared widths, bus encodings and copier state type for the 256x8 memory
package memory_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int MEM_DEPTH  = 256;

   localparam logic CS_ACTIVE = 1'b0;
   localparam logic WR_READ   = 1'b0;
   localparam logic WR_WRITE  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } copier_state_e;

endpackage

// File: rtl/memory_block_copier_copy_checksum.sv
// rtl/memory_block_copier_copy_checksum.sv - modulo-2^DATA_W byte accumulator with clear/enable
// Only present when MEMORY_BLOCK_COPIER_CHECKSUM_EN is defined.
`ifdef MEMORY_BLOCK_COPIER_CHECKSUM_EN
module copy_checksum
   import memory_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] sum
);

   logic [DATA_W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = '0;
      end else if (en) begin
         sum_d = sum_q + din;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule
`endif

// File: rtl/memory_block_copier.sv
// rtl/memory_block_copier.sv - bus initiator copying a byte block within the 256x8 memory
// Optional checksum of written bytes: MEMORY_BLOCK_COPIER_CHECKSUM_EN.
module memory_block_copier
   import memory_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [8:0]        len,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [DATA_W-1:0] checksum,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wr,
   output logic              mem_cs,
   input  logic [DATA_W-1:0] mem_o
);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_READ  = ST_READ;
   localparam logic [1:0] S_WRITE = ST_WRITE;
   localparam logic [1:0] S_DONE  = ST_DONE;
   localparam logic [8:0] LEN_MAX = 9'(MEM_DEPTH);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
   logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
   logic [8:0]        remaining_q, remaining_d;
   logic [DATA_W-1:0] data_reg_q, data_reg_d;
   logic              aborted_q, aborted_d;

   always_comb begin
      state_d     = state_q;
      src_ptr_d   = src_ptr_q;
      dst_ptr_d   = dst_ptr_q;
      remaining_d = remaining_q;
      data_reg_d  = data_reg_q;
      aborted_d   = aborted_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_ptr_d   = src_addr;
               dst_ptr_d   = dst_addr;
               remaining_d = (len > LEN_MAX) ? LEN_MAX : len;
               aborted_d   = 1'b0;
               state_d     = (len == 9'd0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               data_reg_d = mem_o;
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            // The write lands at this edge regardless of abort, so pointers always advance.
            src_ptr_d   = src_ptr_q + ADDR_W'(1);
            dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
            remaining_d = remaining_q - 9'd1;
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else if (remaining_q == 9'd1) begin
               state_d = S_DONE;
            end else begin
               state_d = S_READ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         src_ptr_q   <= '0;
         dst_ptr_q   <= '0;
         remaining_q <= '0;
         data_reg_q  <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_ptr_q   <= src_ptr_d;
         dst_ptr_q   <= dst_ptr_d;
         remaining_q <= remaining_d;
         data_reg_q  <= data_reg_d;
         aborted_q   <= aborted_d;
      end
   end

   // Bus pins decode from registered state only, so start/abort never reach the memory combinationally.
   always_comb begin
      mem_cs      = ~CS_ACTIVE;
      mem_wr      = WR_READ;
      mem_address = '0;
      mem_data    = '0;
      case (state_q)
         S_READ: begin
            mem_cs      = CS_ACTIVE;
            mem_address = src_ptr_q;
         end
         S_WRITE: begin
            mem_cs      = CS_ACTIVE;
            mem_wr      = WR_WRITE;
            mem_address = dst_ptr_q;
            mem_data    = data_reg_q;
         end
         default: begin
            mem_cs = ~CS_ACTIVE;
         end
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign aborted = done & aborted_q;

`ifdef MEMORY_BLOCK_COPIER_CHECKSUM_EN
   logic ck_clr, ck_en;

   assign ck_clr = (state_q == S_IDLE) && start;
   assign ck_en  = (state_q == S_WRITE);

   copy_checksum #(
      .DATA_W (DATA_W)
   ) u_copy_checksum (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (ck_clr),
      .en      (ck_en),
      .din     (data_reg_q),
      .sum     (checksum)
   );
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_memory_block_copier.sv
// tb/tb_memory_block_copier.sv - scoreboard bench for memory_block_copier with a behavioural memory
module tb_memory_block_copier;

`ifdef MEMORY_BLOCK_COPIER_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   typedef struct {
      logic       ab;
      logic [7:0] ck;
      int         cyc;
   } done_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] src_addr = '0;
   logic [7:0] dst_addr = '0;
   logic [8:0] len = '0;
   logic       busy, done, aborted;
   logic [7:0] checksum, mem_address, mem_data, mem_o;
   logic       mem_wr, mem_cs;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic       pre_we = 1'b0;
   logic [7:0] pre_addr = '0;
   logic [7:0] pre_data = '0;

   logic [7:0]  exp_rd [$];
   logic [15:0] exp_wr [$];
   done_t       exp_done [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] last_ck = '0;

   memory_block_copier dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .src_addr    (src_addr),
      .dst_addr    (dst_addr),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .checksum    (checksum),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_wr      (mem_wr),
      .mem_cs      (mem_cs),
      .mem_o       (mem_o)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (!mem_cs && mem_wr) mem[mem_address] <= mem_data;
   end

   assign mem_o = (!mem_cs) ? mem[mem_address] : 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event with nothing expected (t=%0t)", name, $time);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a bus cycle or a done pulse.
   logic [7:0]  mon_a;
   logic [15:0] mon_w;
   done_t       mon_d;
   always @(negedge clock) begin
      if (reset_n) begin
         if (!mem_cs && !mem_wr) begin
            if (exp_rd.size() == 0) unexpected("read");
            else begin
               mon_a = exp_rd.pop_front();
               chk("read_addr", mem_address, mon_a);
            end
         end
         if (!mem_cs && mem_wr) begin
            if (exp_wr.size() == 0) unexpected("write");
            else begin
               mon_w = exp_wr.pop_front();
               chk("write_addr", mem_address, mon_w[15:8]);
               chk("write_data", mem_data, mon_w[7:0]);
            end
         end
         if (done) begin
            if (exp_done.size() == 0) unexpected("done");
            else begin
               mon_d = exp_done.pop_front();
               chk("done_cycle", cyc, mon_d.cyc);
               chk("done_aborted", aborted, mon_d.ab);
               chk("done_checksum", checksum, mon_d.ck);
               chk("busy_in_done", busy, 1);
            end
         end
      end
   end

   // Reference: a copy is a sequence of ascending byte moves over a 256-entry array.
   // mode 0 normal, 1 abort in READ of byte k, 2 abort in WRITE of byte k, 3 reset in WRITE of byte k
   task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                             input int mode, input int k, output logic [7:0] ck);
      int n, nr, nw;
      logic [7:0] v, sum;
      n  = (l > 9'd256) ? 256 : int'(l);
      nr = (mode == 0) ? n : k + 1;
      nw = (mode == 0) ? n : ((mode == 2) ? k + 1 : k);
      sum = '0;
      for (int i = 0; i < nr; i++) exp_rd.push_back(8'(int'(s) + i));
      for (int i = 0; i < nw; i++) begin
         v = ref_mem[8'(int'(s) + i)];
         ref_mem[8'(int'(d) + i)] = v;
         exp_wr.push_back({8'(int'(d) + i), v});
         sum = sum + v;
      end
      ck = CK_EN ? sum : 8'h00;
   endtask

   function automatic int done_lat(input logic [8:0] l, input int mode, input int k);
      int n;
      n = (l > 9'd256) ? 256 : int'(l);
      if (mode == 1) return 2 * k + 2;
      if (mode == 2) return 2 * k + 3;
      return (n == 0) ? 1 : 2 * n + 1;
   endfunction

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 2000) begin
         @(posedge clock);
         #1;
         t++;
      end
      if (t >= 2000) unexpected("idle_timeout");
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      pre_we = 1'b1;
      pre_addr = a;
      pre_data = v;
      ref_mem[a] = v;
      @(posedge clock);
      #1;
      pre_we = 1'b0;
   endtask

   task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                          input int mode, input int k);
      logic [7:0] ck;
      int acc;
      done_t e;
      wait_idle();
      chk("checksum_hold", checksum, last_ck);
      model_copy(s, d, l, mode, k, ck);
      src_addr = s;
      dst_addr = d;
      len = l;
      start = 1'b1;
      @(posedge clock);
      #1;
      acc = cyc;
      start = 1'b0;
      if (mode != 3) begin
         e.ab  = (mode != 0);
         e.ck  = ck;
         e.cyc = acc + done_lat(l, mode, k) - 1;
         exp_done.push_back(e);
         last_ck = ck;
      end
      if (mode == 1 || mode == 2) begin
         repeat ((mode == 1) ? 2 * k : 2 * k + 1) @(posedge clock);
         #1;
         abort = 1'b1;
         @(posedge clock);
         #1;
         abort = 1'b0;
      end else if (mode == 3) begin
         repeat (2 * k + 1) @(posedge clock);
         #2;
         reset_n = 1'b0;
         #1;
         chk("rst_cs_idle", mem_cs, 1);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         @(posedge clock);
         #1;
         reset_n = 1'b1;
         last_ck = 8'h00;
         chk("rst_checksum", checksum, 0);
      end
      wait_idle();
   endtask

   initial begin
      logic [7:0] pat [4];
      logic [7:0] s, d, ck;
      logic [8:0] l;
      int n, mode, k, acc, mism, r;
      done_t e;
      pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

      for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
      for (int i = 0; i < 4; i++) preload(8'(8'h10 + i), pat[i]);

      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_aborted", aborted, 0);
      chk("reset_checksum", checksum, 0);
      chk("reset_cs", mem_cs, 1);
      chk("reset_wr", mem_wr, 0);
      chk("reset_addr", mem_address, 0);
      chk("reset_data", mem_data, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      do_copy(8'h10, 8'h80, 9'd4, 0, 0);
      for (int i = 0; i < 4; i++) chk("directed_dst", mem[8'(8'h80 + i)], pat[i]);
      if (CK_EN) chk("directed_checksum", checksum, 8'h0E);

      do_copy(8'h33, 8'h44, 9'd0, 0, 0);
      do_copy(8'hFE, 8'h02, 9'd4, 0, 0);
      do_copy(8'h20, 8'h90, 9'd8, 1, 2);
      do_copy(8'h40, 8'hA0, 9'd8, 2, 5);
      do_copy(8'h50, 8'hB0, 9'd8, 3, 2);
      do_copy(8'h60, 8'hC0, 9'd5, 0, 0);

      // Back-to-back: start held high across two len=1 copies.
      wait_idle();
      s = 8'($urandom);
      d = 8'($urandom);
      model_copy(s, d, 9'd1, 0, 0, ck);
      model_copy(8'(s + 1), 8'(d + 1), 9'd1, 0, 0, ck);
      src_addr = s;
      dst_addr = d;
      len = 9'd1;
      start = 1'b1;
      @(posedge clock);
      #1;
      acc = cyc;
      src_addr = 8'(s + 1);
      dst_addr = 8'(d + 1);
      e.ab = 1'b0;
      e.ck = (CK_EN) ? ref_mem[d] : 8'h00;
      e.cyc = acc + 2;
      exp_done.push_back(e);
      e.ck = ck;
      e.cyc = acc + 6;
      exp_done.push_back(e);
      repeat (4) @(posedge clock);
      #1;
      start = 1'b0;
      last_ck = ck;
      wait_idle();

      for (int it = 0; it < 25; it++) begin
         r = $urandom_range(9, 0);
         if (r == 0) l = 9'd0;
         else if (r == 1) l = 9'(256 + $urandom_range(255, 0));
         else l = 9'($urandom_range(16, 1));
         n = (l > 9'd256) ? 256 : int'(l);
         mode = (n > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
         k = (mode != 0) ? int'($urandom_range(n - 1, 0)) : 0;
         do_copy(8'($urandom), 8'($urandom), l, mode, k);
      end

      repeat (3) @(posedge clock);
      #1;
      chk("rd_queue_empty", exp_rd.size(), 0);
      chk("wr_queue_empty", exp_wr.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);
      mism = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
      chk("memory_image", mism, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
